tl_sensor_cond: RTL and testbench



---
 rtl/tl_pkg.sv | 34 +++
 rtl/tl_sensor_lane.sv | 133 +++++++++++++
 rtl/tl_sensor_cond.sv | 83 ++++++++
 tb/tb_tl_sensor_cond.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tl_pkg
//  Purpose  : Shared definitions for the traffic-light sensor conditioning
//             slice: lane FSM state type, default debounce/hold lengths,
//             car-count width and a counter-width helper.
//  Ports    : none (package)
//  Options  : TL_CAR_CNT_EN (consumers add per-lane car counters)
//  Revision : 1.0  initial release
// ============================================================================
package tl_pkg;

  // Lane FSM states; the encoding is fixed so that waveforms and any
  // downstream debug taps read the same on every build.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ARM    = 2'b01,
    ST_ACTIVE = 2'b10,
    ST_HOLD   = 2'b11
  } lane_state_t;

  localparam int unsigned c_deb_cyc_def  = 4;
  localparam int unsigned c_hold_cyc_def = 8;
  localparam int unsigned c_car_cnt_w    = 8;

  // One extra bit above what the larger limit needs, so the terminal value
  // always fits even when a limit is an exact power of two.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage : tl_pkg
`default_nettype wire

// File: rtl/tl_sensor_lane.sv
`default_nettype none
// ============================================================================
//  Module   : tl_sensor_lane
//  Purpose  : One detector lane: 2-flop synchroniser, debounce/hold FSM with
//             its shared counter, and (optionally) a saturating count of
//             debounced vehicle arrivals.
//  Ports    : clk        - system clock, rising edge
//             reset      - asynchronous active-high reset
//             i_raw      - raw asynchronous detector line
//             o_flag     - registered, conditioned traffic-present flag
//             o_car_cnt  - ARM->ACTIVE count, saturating (TL_CAR_CNT_EN only)
//  Options  : TL_CAR_CNT_EN adds o_car_cnt and its register.
//  Revision : 1.0  initial release
// ============================================================================
module tl_sensor_lane
  import tl_pkg::*;
#(
  parameter int unsigned DEB_CYC  = c_deb_cyc_def,
  parameter int unsigned HOLD_CYC = c_hold_cyc_def
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_flag
`ifdef TL_CAR_CNT_EN
  ,
  output logic [c_car_cnt_w-1:0] o_car_cnt
`endif
);

  localparam int unsigned c_cnt_w = cnt_width(DEB_CYC, HOLD_CYC);

  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEB_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_hld_last = c_cnt_w'(HOLD_CYC - 1);

  logic               r_sync1;
  logic               r_sync2;
  lane_state_t        r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_flag;

  // Debounce completes on the DEB_CYC-th consecutive synchronised-high
  // sample; this is the only event that counts as a new vehicle.
  logic w_arm_to_active;
  logic w_hold_done;

  assign w_arm_to_active = (r_state == ST_ARM)  &&  r_sync2 && (r_cnt == c_deb_last);
  assign w_hold_done     = (r_state == ST_HOLD) && !r_sync2 && (r_cnt == c_hld_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;

      case (r_state)
        ST_IDLE: begin
          if (r_sync2) begin
            r_state <= ST_ARM;
            r_cnt   <= c_cnt_one;
          end
        end

        ST_ARM: begin
          if (!r_sync2) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (w_arm_to_active) begin
            r_state <= ST_ACTIVE;
            r_cnt   <= '0;
            r_flag  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        ST_ACTIVE: begin
          if (!r_sync2) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
          end
        end

        ST_HOLD: begin
          // A returning vehicle during hold goes straight back to ACTIVE:
          // the flag is still high, so there is nothing to debounce.
          if (r_sync2) begin
            r_state <= ST_ACTIVE;
            r_cnt   <= '0;
          end else if (w_hold_done) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_flag  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_flag  <= 1'b0;
        end
      endcase
    end
  end

  assign o_flag = r_flag;

`ifdef TL_CAR_CNT_EN
  localparam logic [c_car_cnt_w-1:0] c_car_max = {c_car_cnt_w{1'b1}};

  logic [c_car_cnt_w-1:0] r_car_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_car_cnt <= '0;
    end else if (w_arm_to_active && (r_car_cnt != c_car_max)) begin
      r_car_cnt <= r_car_cnt + c_car_cnt_w'(1);
    end
  end

  assign o_car_cnt = r_car_cnt;
`endif

endmodule : tl_sensor_lane
`default_nettype wire

// File: rtl/tl_sensor_cond.sv
`default_nettype none
// ============================================================================
//  Module   : tl_sensor_cond
//  Purpose  : Conditions the four raw vehicle-detector lines of the left-turn
//             traffic-light controller into clean, registered traffic flags.
//             Each lane is synchronised, debounced and hold-stretched
//             independently.
//  Ports    : clk                     - system clock, rising edge
//             reset                   - asynchronous active-high reset
//             raw_a/raw_al/raw_b/raw_bl - raw asynchronous detector lines
//             Ta/Tal/Tb/Tbl           - conditioned traffic-present flags
//             cnt_a/cnt_al/cnt_b/cnt_bl - 8-bit saturating car counts
//                                       (TL_CAR_CNT_EN only)
//  Options  : TL_CAR_CNT_EN adds the per-lane car-count outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tl_sensor_cond
  import tl_pkg::*;
#(
  parameter int unsigned DEB_CYC  = c_deb_cyc_def,
  parameter int unsigned HOLD_CYC = c_hold_cyc_def
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_a,
  input  logic raw_al,
  input  logic raw_b,
  input  logic raw_bl,
  output logic Ta,
  output logic Tal,
  output logic Tb,
  output logic Tbl
`ifdef TL_CAR_CNT_EN
  ,
  output logic [c_car_cnt_w-1:0] cnt_a,
  output logic [c_car_cnt_w-1:0] cnt_al,
  output logic [c_car_cnt_w-1:0] cnt_b,
  output logic [c_car_cnt_w-1:0] cnt_bl
`endif
);

  localparam int unsigned c_lanes = 4;

  // Lane order: 0 = A straight, 1 = A left, 2 = B straight, 3 = B left.
  logic [c_lanes-1:0] w_raw;
  logic [c_lanes-1:0] w_flag;
`ifdef TL_CAR_CNT_EN
  logic [c_car_cnt_w-1:0] w_car_cnt [c_lanes];
`endif

  assign w_raw = {raw_bl, raw_b, raw_al, raw_a};

  for (genvar g = 0; g < c_lanes; g++) begin : g_lane
    tl_sensor_lane #(
      .DEB_CYC  (DEB_CYC),
      .HOLD_CYC (HOLD_CYC)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .i_raw     (w_raw[g]),
      .o_flag    (w_flag[g])
`ifdef TL_CAR_CNT_EN
      ,
      .o_car_cnt (w_car_cnt[g])
`endif
    );
  end

  // Flags come straight from lane registers: no input-to-output logic.
  assign Ta  = w_flag[0];
  assign Tal = w_flag[1];
  assign Tb  = w_flag[2];
  assign Tbl = w_flag[3];

`ifdef TL_CAR_CNT_EN
  assign cnt_a  = w_car_cnt[0];
  assign cnt_al = w_car_cnt[1];
  assign cnt_b  = w_car_cnt[2];
  assign cnt_bl = w_car_cnt[3];
`endif

endmodule : tl_sensor_cond
`default_nettype wire

// File: tb/tb_tl_sensor_cond.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tl_sensor_cond
//  Purpose  : Self-checking bench for tl_sensor_cond. A behavioural model
//             tracks, per lane, the raw level delayed by two edges and the
//             lengths of the current high/low runs; the flag rises after
//             DEB_CYC consecutive highs and falls after HOLD_CYC+1
//             consecutive lows. Directed scenarios plus random bursts.
//  Options  : TL_CAR_CNT_EN also checks the saturating car counts.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tl_sensor_cond;

  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] raw   = 4'b0000;
  logic       Ta, Tal, Tb, Tbl;
`ifdef TL_CAR_CNT_EN
  logic [7:0] cnt_a, cnt_al, cnt_b, cnt_bl;
`endif

  tl_sensor_cond #(
    .DEB_CYC  (DEB),
    .HOLD_CYC (HOLD)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .raw_a  (raw[0]),
    .raw_al (raw[1]),
    .raw_b  (raw[2]),
    .raw_bl (raw[3]),
    .Ta     (Ta),
    .Tal    (Tal),
    .Tb     (Tb),
    .Tbl    (Tbl)
`ifdef TL_CAR_CNT_EN
    ,
    .cnt_a  (cnt_a),
    .cnt_al (cnt_al),
    .cnt_b  (cnt_b),
    .cnt_bl (cnt_bl)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  string lane_name [4] = '{"Ta", "Tal", "Tb", "Tbl"};

  // Reference model state
  logic m_d1 [4];
  logic m_d2 [4];
  logic m_flag [4];
  int   m_hi [4];
  int   m_lo [4];
  int   m_cars [4];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 4; l++) begin
      m_d1[l] = 1'b0; m_d2[l] = 1'b0; m_flag[l] = 1'b0;
      m_hi[l] = 0;    m_lo[l] = 0;    m_cars[l] = 0;
    end
  endtask

  // Called just after a rising edge; raw has not changed since that edge.
  task automatic model_step();
    for (int l = 0; l < 4; l++) begin
      if (m_d2[l]) begin
        m_hi[l]++;
        m_lo[l] = 0;
      end else begin
        m_lo[l]++;
        m_hi[l] = 0;
      end
      if (!m_flag[l] && m_hi[l] >= DEB) begin
        m_flag[l] = 1'b1;
        if (m_cars[l] < 255) m_cars[l]++;
      end else if (m_flag[l] && m_lo[l] >= HOLD + 1) begin
        m_flag[l] = 1'b0;
      end
      m_d2[l] = m_d1[l];
      m_d1[l] = raw[l];
    end
  endtask

  function automatic logic [3:0] dut_flags();
    return {Tbl, Tb, Tal, Ta};
  endfunction

`ifdef TL_CAR_CNT_EN
  function automatic logic [7:0] dut_cnt(input int l);
    case (l)
      0:       return cnt_a;
      1:       return cnt_al;
      2:       return cnt_b;
      default: return cnt_bl;
    endcase
  endfunction
`endif

  task automatic check_all(input string tag);
    logic [3:0] f;
    f = dut_flags();
    for (int l = 0; l < 4; l++) begin
      check({tag, "_", lane_name[l]}, {7'd0, f[l]}, {7'd0, m_flag[l]});
`ifdef TL_CAR_CNT_EN
      check({tag, "_cnt_", lane_name[l]}, dut_cnt(l), 8'(m_cars[l]));
`endif
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  int       rem [4];
  int       prev_cnt;
  string    s;

  initial begin
    model_reset();

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_Ta",  {7'd0, Ta},  8'd0);
    check("rst_Tal", {7'd0, Tal}, 8'd0);
    check("rst_Tb",  {7'd0, Tb},  8'd0);
    check("rst_Tbl", {7'd0, Tbl}, 8'd0);
    reset = 1'b0;
    ticks("idle", 3);

    // ---------------- debounce rise on A ----------------
    raw[0] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick("deb");
      s = $sformatf("deb_Ta_e%0d", e);
      check(s, {7'd0, Ta}, 8'd0);
    end
    tick("deb");
    check("deb_Ta_e6", {7'd0, Ta}, 8'd1);
    ticks("deb_hi", 3);

    // ---------------- reset three cycles into hold ----------------
    raw[0] = 1'b0;
    ticks("pre_rst", 6);
    check("pre_rst_Ta", {7'd0, Ta}, 8'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_Ta", {7'd0, Ta}, 8'd0);
    check("async_rst_flags", {4'd0, dut_flags()}, 8'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick("post_rst");
      check("post_rst_Ta", {7'd0, Ta}, 8'd0);
    end

    // ---------------- glitch rejection on B ----------------
    raw[2] = 1'b1;
    ticks("glitch", 3);
    raw[2] = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick("glitch");
      check("glitch_Tb", {7'd0, Tb}, 8'd0);
    end
    // A full-length press afterwards must still take exactly DEB_CYC+2 edges.
    raw[2] = 1'b1;
    ticks("after_glitch", 5);
    check("after_glitch_Tb_e5", {7'd0, Tb}, 8'd0);
    tick("after_glitch");
    check("after_glitch_Tb_e6", {7'd0, Tb}, 8'd1);
    raw[2] = 1'b0;
    ticks("b_release", 12);

    // ---------------- hold release on A-left ----------------
    raw[1] = 1'b1;
    ticks("al_rise", 8);
    check("al_up", {7'd0, Tal}, 8'd1);
    raw[1] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick("al_hold");
      s = $sformatf("hold_Tal_e%0d", e);
      check(s, {7'd0, Tal}, 8'd1);
    end
    tick("al_hold");
    check("hold_Tal_e11", {7'd0, Tal}, 8'd0);
    ticks("al_idle", 2);

    // ---------------- hold re-trigger on B-left ----------------
`ifdef TL_CAR_CNT_EN
    prev_cnt = int'(cnt_bl);
`else
    prev_cnt = 0;
`endif
    raw[3] = 1'b1;
    ticks("bl_rise", 8);
    raw[3] = 1'b0;
    ticks("bl_drop", 5);
    raw[3] = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick("bl_retrig");
      check("retrig_Tbl", {7'd0, Tbl}, 8'd1);
    end
`ifdef TL_CAR_CNT_EN
    check("retrig_cnt_bl", cnt_bl, 8'(prev_cnt + 1));
`endif
    raw[3] = 1'b0;
    ticks("bl_release", 12);

    // ---------------- random bursts on all lanes ----------------
    for (int l = 0; l < 4; l++) rem[l] = $urandom_range(1, 14);
    for (int c = 0; c < 400; c++) begin
      for (int l = 0; l < 4; l++) begin
        if (rem[l] == 0) begin
          raw[l] = ~raw[l];
          rem[l] = $urandom_range(1, 14);
        end
        rem[l]--;
      end
      tick("rand");
    end
    raw = 4'b0000;
    ticks("rand_drain", 14);

`ifdef TL_CAR_CNT_EN
    // ---------------- car-count saturation on A ----------------
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int p = 0; p < 260; p++) begin
      raw[0] = 1'b1;
      ticks("sat", 5);
      raw[0] = 1'b0;
      ticks("sat", 12);
    end
    check("sat_cnt_a", cnt_a, 8'd255);
    raw[0] = 1'b1;
    ticks("sat_more", 8);
    raw[0] = 1'b0;
    ticks("sat_more", 12);
    check("sat_hold_cnt_a", cnt_a, 8'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_tl_sensor_cond
`default_nettype wire
